// File: rtl/sr_mem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory: one registered access cycle, then a one-cycle response.
// Build option: define SR_MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module sr_mem_arbiter #(
    parameter int MEMORY_SIZE = 256,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [31:0]       req0_wdata,
    output logic              resp0_valid,
    output logic [31:0]       resp0_rdata,
    output logic              resp0_err,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [31:0]       req1_wdata,
    output logic              resp1_valid,
    output logic [31:0]       resp1_rdata,
    output logic              resp1_err,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_we,
    output logic [31:0]       mem_wd,
    input  logic [31:0]       mem_rd,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEMORY_SIZE - 4);

    state_t              state_q, state_d;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic                port_q;
    logic [31:0]         rdata_q;
    logic                err_q;

    logic                window;
    logic                win1;
    logic                accept;
    logic                in_range;

    assign window   = (state_q != ACCESS);
    assign accept   = window && (req0_valid || req1_valid);
    assign in_range = (addr_q <= LAST_WORD);

`ifdef SR_MEM_ARB_ROUND_ROBIN_EN
    // last_q holds the port granted most recently; reset to port 1 so port 0 wins first
    logic last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= 1'b1;
        end else if (accept) begin
            last_q <= win1;
        end
    end

    assign win1 = req1_valid && (!req0_valid || !last_q);
`else
    assign win1 = req1_valid && !req0_valid;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ACCESS;
            ACCESS:  state_d = RESP;
            RESP:    state_d = accept ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req0_ready  = window && req0_valid && !win1;
        req1_ready  = window && win1;
        mem_we      = (state_q == ACCESS) && we_q && in_range;
        busy        = (state_q != IDLE);
        resp0_valid = (state_q == RESP) && !port_q;
        resp1_valid = (state_q == RESP) && port_q;
        resp0_err   = resp0_valid && err_q;
        resp1_err   = resp1_valid && err_q;
    end

    // Request capture: these registers drive the memory directly, so they also hold mem_a/mem_wd between accesses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            port_q  <= 1'b0;
        end else if (accept) begin
            we_q    <= win1 ? req1_we    : req0_we;
            addr_q  <= win1 ? req1_addr  : req0_addr;
            wdata_q <= win1 ? req1_wdata : req0_wdata;
            port_q  <= win1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (state_q == ACCESS) begin
            rdata_q <= (!we_q && in_range) ? mem_rd : 32'd0;
            err_q   <= !in_range;
        end
    end

    assign mem_a       = addr_q;
    assign mem_wd      = wdata_q;
    assign resp0_rdata = rdata_q;
    assign resp1_rdata = rdata_q;

endmodule

// File: tb/tb_sr_mem_arbiter.sv
// Bench for sr_mem_arbiter: directed scenarios plus random traffic against a transaction-timing reference model.
module tb_sr_mem_arbiter;

    localparam int MS = 256;
    localparam int AW = 32;
`ifdef SR_MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          v[2];
    logic          we_s[2];
    logic [31:0]   addr_s[2];
    logic [31:0]   wd_s[2];
    logic          r0, r1, rv0, rv1, re0, re1, mem_we, busy;
    logic [31:0]   rd0, rd1, mem_wd, mem_rd;
    logic [AW-1:0] mem_a;

    sr_mem_arbiter #(.MEMORY_SIZE(MS), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(v[0]), .req0_ready(r0), .req0_we(we_s[0]), .req0_addr(addr_s[0]),
        .req0_wdata(wd_s[0]), .resp0_valid(rv0), .resp0_rdata(rd0), .resp0_err(re0),
        .req1_valid(v[1]), .req1_ready(r1), .req1_we(we_s[1]), .req1_addr(addr_s[1]),
        .req1_wdata(wd_s[1]), .resp1_valid(rv1), .resp1_rdata(rd1), .resp1_err(re1),
        .mem_a(mem_a), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd), .busy(busy)
    );

    // Environment memory seen by the DUT
    logic [7:0] tmem[MS];
    logic [7:0] ref_m[MS];
    int         oor_w = 0;

    always_comb begin
        mem_rd = 32'hBAD0BAD0;
        if (mem_a <= 32'd252)
            mem_rd = {tmem[mem_a[7:0] + 8'd3], tmem[mem_a[7:0] + 8'd2],
                      tmem[mem_a[7:0] + 8'd1], tmem[mem_a[7:0]]};
    end

    always @(posedge clk) begin
        if (mem_we) begin
            if (mem_a <= 32'd252) begin
                for (int b = 0; b < 4; b++) tmem[int'(mem_a) + b] = mem_wd[8*b +: 8];
            end else begin
                oor_w++;
            end
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic logic [31:0] ref_rd(input int a);
        return {ref_m[a+3], ref_m[a+2], ref_m[a+1], ref_m[a]};
    endfunction

    // Reference model: an access accepted in cycle c owns the memory in c+1 and responds in c+2
    int          cyc = 0;
    int          last_acc = -100;
    int          ptr = 1;
    logic        t_we;
    logic [31:0] t_addr, t_wd, t_rdata;
    int          t_port;
    logic        t_err;
    logic [31:0] held_a = 0, held_wd = 0;
    bit          acc_flag[2];
    int          grant_log[$];
    logic [31:0] obs_rd[2];
    logic        obs_err[2];
    int          resp_cnt[2];
    int          we_cycles = 0;

    task automatic model_reset();
        last_acc = -100;
        ptr      = 1;
        held_a   = 0;
        held_wd  = 0;
        acc_flag[0] = 0;
        acc_flag[1] = 0;
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            int  w;
            bit  inr;
            w = -1;
            if (cyc != last_acc + 1) begin
                if (v[0] && v[1]) w = RR ? (ptr == 1 ? 0 : 1) : 0;
                else if (v[0])    w = 0;
                else if (v[1])    w = 1;
            end
            chk("ready0", r0, w == 0);
            chk("ready1", r1, w == 1);
            chk("busy", busy, (cyc == last_acc + 1) || (cyc == last_acc + 2));
            chk("mem_a_hold", mem_a, held_a);
            chk("mem_wd_hold", mem_wd, held_wd);
            if (mem_we) we_cycles++;
            if (cyc == last_acc + 1) begin
                inr = (t_addr <= 32'd252);
                chk("mem_we", mem_we, t_we && inr);
                t_rdata = (!t_we && inr) ? ref_rd(int'(t_addr)) : 32'd0;
                if (t_we && inr)
                    for (int b = 0; b < 4; b++) ref_m[int'(t_addr) + b] = t_wd[8*b +: 8];
                t_err = !inr;
            end else begin
                chk("mem_we_idle", mem_we, 0);
            end
            if (cyc == last_acc + 2) begin
                chk("resp0_valid", rv0, t_port == 0);
                chk("resp1_valid", rv1, t_port == 1);
                chk("resp_rdata", (t_port == 0) ? rd0 : rd1, t_rdata);
                chk("resp_err", (t_port == 0) ? re0 : re1, t_err);
            end else begin
                chk("resp_idle", {rv0, rv1}, 0);
            end
            if (rv0) begin obs_rd[0] = rd0; obs_err[0] = re0; resp_cnt[0]++; end
            if (rv1) begin obs_rd[1] = rd1; obs_err[1] = re1; resp_cnt[1]++; end
            if (w >= 0) begin
                ptr      = w;
                last_acc = cyc;
                t_we     = we_s[w];
                t_addr   = addr_s[w];
                t_wd     = wd_s[w];
                t_port   = w;
                held_a   = addr_s[w];
                held_wd  = wd_s[w];
                acc_flag[w] = 1;
                grant_log.push_back(w);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            if (acc_flag[p]) begin
                v[p] = 1'b0;
                acc_flag[p] = 0;
            end
        end
    endtask

    task automatic do_req(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
        v[p] = 1'b1; we_s[p] = we; addr_s[p] = a; wd_s[p] = d;
        for (int i = 0; i < 50; i++) begin
            step();
            if (!v[p]) return;
        end
        chk("req_timeout", 0, 1);
        v[p] = 1'b0;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        v[0] = 1'b0; v[1] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic rand_req(input int p);
        logic [31:0] a;
        case ($urandom % 8)
            0, 1, 2, 3, 4: a = {22'd0, 8'($urandom % 64), 2'b00};
            5:             a = $urandom_range(240, 260);
            6:             a = $urandom_range(249, 256);
            default:       a = $urandom;
        endcase
        v[p] = 1'b1; we_s[p] = 1'($urandom % 2); addr_s[p] = a; wd_s[p] = $urandom;
    endtask

    initial begin
        int wc0, rc0, diffs;
        for (int i = 0; i < MS; i++) begin
            tmem[i]  = 8'($urandom);
            ref_m[i] = tmem[i];
        end
        for (int p = 0; p < 2; p++) begin
            v[p] = 0; we_s[p] = 0; addr_s[p] = 0; wd_s[p] = 0;
        end
        #1;
        chk("rst_ready", {r0, r1}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_a", mem_a, 0);
        chk("rst_mem_wd", mem_wd, 0);
        chk("rst_resp", {rv0, rv1, re0, re1}, 0);
        chk("rst_rdata", rd0, 0);
        reset_dut();

        // Write then read back through port 0
        wc0 = we_cycles;
        do_req(0, 1'b1, 32'h10, 32'hDEADBEEF);
        step(); step();
        chk("wr_pulse", we_cycles - wc0, 1);
        chk("wr_rdata", obs_rd[0], 0);
        chk("wr_err", obs_err[0], 0);
        do_req(0, 1'b0, 32'h10, 32'h0);
        step(); step();
        chk("rd_10", obs_rd[0], 32'hDEADBEEF);
        chk("rd_10_err", obs_err[0], 0);

        // Out-of-range write from port 1
        wc0 = we_cycles;
        do_req(1, 1'b1, MS - 3, 32'hCAFEF00D);
        step(); step();
        chk("oor_we", we_cycles - wc0, 0);
        chk("oor_err", obs_err[1], 1);
        chk("oor_rdata", obs_rd[1], 0);
        chk("oor_mem", {tmem[255], tmem[254], tmem[253], tmem[252]}, ref_rd(252));

        // Last in-range word
        do_req(0, 1'b1, 32'd252, 32'h01020304);
        step(); step();
        do_req(0, 1'b0, 32'd252, 32'h0);
        step(); step();
        chk("rd_252", obs_rd[0], 32'h01020304);
        chk("rd_252_err", obs_err[0], 0);

        // Both ports held valid continuously
        reset_dut();
        grant_log.delete();
        v[0] = 1; we_s[0] = 0; addr_s[0] = 32'h0; wd_s[0] = 0;
        v[1] = 1; we_s[1] = 0; addr_s[1] = 32'h4; wd_s[1] = 0;
        for (int i = 0; i < 40 && grant_log.size() < 8; i++) begin
            step();
            if (!v[0]) v[0] = 1;
            if (!v[1]) v[1] = 1;
        end
        chk("grant_cnt", grant_log.size() >= 8, 1);
        for (int i = 0; i < 8 && i < grant_log.size(); i++)
            chk($sformatf("grant_%0d", i), grant_log[i], RR ? (i % 2) : 0);
        v[0] = 0; v[1] = 0;
        repeat (3) step();

        // Back-to-back reads from port 0
        rc0 = resp_cnt[0];
        v[0] = 1; we_s[0] = 0; addr_s[0] = 32'h20; wd_s[0] = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (!v[0]) begin v[0] = 1; addr_s[0] = {22'd0, 8'($urandom % 64), 2'b00}; end
        end
        v[0] = 0;
        repeat (3) step();
        chk("b2b_cnt", (resp_cnt[0] - rc0 >= 10) && (resp_cnt[0] - rc0 <= 11), 1);

        // Reset during the access cycle of a write
        do_req(0, 1'b1, 32'h30, 32'h55AA55AA);
        #1;
        chk("pre_rst_we", mem_we, 1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_mid_we", mem_we, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_resp", {rv0, rv1}, 0);
        #1;
        rst_n = 1'b1;
        step();
        chk("rst_mid_mem", {tmem[51], tmem[50], tmem[49], tmem[48]}, ref_rd(48));
        do_req(0, 1'b0, 32'h30, 32'h0);
        step(); step();
        chk("post_rst_rd", obs_rd[0], ref_rd(48));

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            step();
            for (int p = 0; p < 2; p++) begin
                if (!v[p]) begin
                    if ($urandom % 3 == 0) rand_req(p);
                end else if ($urandom % 12 == 0) begin
                    v[p] = 0;
                end
            end
        end
        v[0] = 0; v[1] = 0;
        repeat (4) step();

        diffs = 0;
        for (int i = 0; i < MS; i++) if (tmem[i] !== ref_m[i]) diffs++;
        chk("mem_final", diffs, 0);
        chk("oor_writes", oor_w, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
